// File: rtl/sequential_multiplier.sv
// Unsigned shift-and-add multiplier. Each busy cycle consumes one multiplier
// bit. A busy flag and a down-counter sequence the operation. The result
// appears on z together with a one-cycle z_valid strobe.
module sequential_multiplier #(
    parameter int Multiplicand_length = 5,
    parameter int Multiplier_length   = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [Multiplicand_length-1:0]                 a,
    input  logic [Multiplier_length-1:0]                   b,
    input  logic                                           ab_valid,
    output logic                                           ab_ready,
    output logic [Multiplicand_length+Multiplier_length-1:0] z,
    output logic                                           z_valid
);

    localparam int N  = Multiplicand_length;
    localparam int M  = Multiplier_length;
    localparam int W  = N + M;
    localparam int CW = $clog2(M + 1);

    logic          busy;
    logic [CW-1:0] count;
    logic [W-1:0]  mcand;
    logic [M-1:0]  mplier;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_next;

    // Idle means ready. No buffering happens: operands offered while busy are dropped.
    assign ab_ready = ~busy;

    // Accumulator value after this cycle's conditional add.
    always_comb begin
        // NOTE: default first so every path assigns acc_next and no latch is inferred.
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Accept operands, step the datapath while busy, publish the result on the last step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: every register here is a flop with no memory array, so all of them
            // are reset and abort cleanly mid-operation.
            busy    <= 1'b0;
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            z       <= '0;
            z_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every read below sees the pre-edge value.
            z_valid <= 1'b0;
            if (!busy) begin
                // a and b are sampled only here, so idle X/Z on them cannot reach z.
                if (ab_valid) begin
                    mcand  <= {{M{1'b0}}, a};
                    mplier <= b;
                    acc    <= '0;
                    count  <= CW'(M);
                    busy   <= 1'b1;
                end
            end else begin
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - 1'b1;
                if (count == CW'(1)) begin
                    z       <= acc_next;
                    z_valid <= 1'b1;
                    busy    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier. The bench pushes expected
// products to a queue at each accept edge. It pops and compares them on each
// z_valid strobe. Directed vectors, multi-cycle corner sequences and a random
// soak follow.
module tb_sequential_multiplier;

    localparam int N = 5;
    localparam int M = 2;
    localparam int W = N + M;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic         ab_valid;
    logic         ab_ready;
    logic [W-1:0] z;
    logic         z_valid;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] sb_q[$];

    typedef struct {
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    sequential_multiplier #(
        .Multiplicand_length(N),
        .Multiplier_length  (M)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .b       (b),
        .ab_valid(ab_valid),
        .ab_ready(ab_ready),
        .z       (z),
        .z_valid (z_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard producer: an accept edge pushes the reference product.
    always @(posedge clk) begin
        if (rst === 1'b1 && ab_valid === 1'b1 && ab_ready === 1'b1) begin
            sb_q.push_back(W'(a) * W'(b));
        end
    end

    // Scoreboard consumer: every strobe must match the oldest outstanding product.
    always @(negedge clk) begin
        if (z_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_z_valid", 32'(z_valid), 32'd0);
            end else begin
                check("scoreboard_z", 32'(z), 32'(sb_q.pop_front()));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Accept one operand pair, then check latency, the result, the strobe width and that z holds.
    task automatic run_op(input logic [N-1:0] va, input logic [M-1:0] vb, input logic [W-1:0] exp);
        int n;
        @(negedge clk);
        a = va; b = vb; ab_valid = 1'b1;
        @(negedge clk);
        ab_valid = 1'b0; a = 'x; b = 'x;
        check("ready_low_after_accept", 32'(ab_ready), 32'd0);
        n = 0;
        while (z_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'(M));
        check("z_result", 32'(z), 32'(exp));
        check("ready_in_result_cycle", 32'(ab_ready), 32'd1);
        @(negedge clk);
        check("z_valid_one_cycle", 32'(z_valid), 32'd0);
        check("z_holds", 32'(z), 32'(exp));
    endtask

    initial begin
        int n;
        rst = 1'b0; a = '0; b = '0; ab_valid = 1'b0;

        vecs[0] = '{a: 5'd31, b: 2'd3, exp: 7'd93};
        vecs[1] = '{a: 5'd17, b: 2'd0, exp: 7'd0};
        vecs[2] = '{a: 5'd0,  b: 2'd2, exp: 7'd0};
        vecs[3] = '{a: 5'd1,  b: 2'd1, exp: 7'd1};
        vecs[4] = '{a: 5'd21, b: 2'd2, exp: 7'd42};
        vecs[5] = '{a: 5'd7,  b: 2'd3, exp: 7'd21};

        // Reset state
        #12;
        check("reset_z", 32'(z), 32'd0);
        check("reset_z_valid", 32'(z_valid), 32'd0);
        check("reset_ab_ready", 32'(ab_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_no_strobe", 32'(z_valid), 32'd0);
        end

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Busy ignore: 31x3 offered while busy is taken only at the next ready edge
        @(negedge clk);
        a = 5'd5; b = 2'd1; ab_valid = 1'b1;
        @(negedge clk);
        a = 5'd31; b = 2'd3;
        n = 0;
        while (z_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("busy_first_z", 32'(z), 32'd5);
        @(negedge clk);
        ab_valid = 1'b0;
        n = 1;
        while (z_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("busy_second_gap", 32'(n), 32'd3);
        check("busy_second_z", 32'(z), 32'd93);

        // Reset mid-operation
        @(negedge clk);
        a = 5'd12; b = 2'd3; ab_valid = 1'b1;
        @(negedge clk);
        ab_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        #1;
        check("midop_z", 32'(z), 32'd0);
        check("midop_z_valid", 32'(z_valid), 32'd0);
        check("midop_ab_ready", 32'(ab_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midop_no_strobe", 32'(z_valid), 32'd0);
        end

        // Random soak
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            ab_valid = 1'($urandom_range(0, 1));
            a = N'($urandom);
            b = M'($urandom);
        end
        @(negedge clk);
        ab_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("soak_queue_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sequential_multiplier.md
Name: sequential_multiplier

Overview:
- Unsigned sequential shift-and-add multiplier; multiplies an N-bit multiplicand by an M-bit multiplier, one multiplier bit per clock.
- Sits between a valid/ready producer and a consumer that takes a one-cycle result strobe.
- Control is a busy flag plus a bit counter; no encoded state machine.

Parameters:
- Multiplicand_length, 5, width N of operand a.
- Multiplier_length, 2, width M of operand b; also the number of compute cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- a  input  N  multiplicand, unsigned.
- b  input  M  multiplier, unsigned.
- ab_valid  input  1  operands present on a/b.
- ab_ready  output  1  block idle and able to accept operands.
- z  output  N+M  product a*b, unsigned, full width.
- z_valid  output  1  one-cycle strobe marking z as a new result.

Behaviour:
- Reset (rst=0, async, independent of clk):
  - busy=0, counter=0, accumulator=0.
  - z=0, z_valid=0.
  - ab_ready=1, since ab_ready is the inverse of busy.
- ab_ready = !busy, combinational.
- Accept: at a rising edge where ab_valid=1 and ab_ready=1:
  - latch a zero-extended to N+M bits into the multiplicand shift register.
  - latch b into the multiplier shift register.
  - clear the accumulator; load counter=M; set busy=1.
- While busy, a, b and ab_valid are ignored.
- Compute step, each rising edge while busy:
  - if the multiplier LSB is 1, accumulator += multiplicand, modulo 2^(N+M); the true product never overflows.
  - multiplicand <<= 1; multiplier >>= 1; counter -= 1.
- On the M-th compute edge:
  - z <= final accumulator value, including that step's addition.
  - z_valid <= 1; busy <= 0.
- Latency: operands accepted at edge k; ab_ready low from edge k to edge k+M; z_valid high from edge k+M to edge k+M+1, exactly one cycle.
- Back-to-back: ab_ready is 1 during the z_valid cycle, so a new accept at edge k+M+1 is legal. Throughput is one product per M+1 cycles.
- z holds its value until the next result or reset. z_valid is 0 in every cycle that is not a result cycle.
- Zero operands still take M cycles and produce z=0 with z_valid pulsed.
- Reset mid-operation aborts the computation immediately: no z_valid, z=0, ab_ready=1.
- ab_valid=1 while busy has no effect; it is neither queued nor buffered.
- X/Z on a/b while not accepting must not propagate into z.

Test Plan:
- Reset: hold rst=0, then release. Required: z=0, z_valid=0, ab_ready=1; no z_valid pulse while ab_valid=0.
- Maximum operands: a=31, b=3, ab_valid=1 for one accept edge. Required: ab_ready low 2 cycles, then z=93 with z_valid high exactly 1 cycle; z stays 93 afterwards.
- Zero operands: a=17, b=0 gives z=0 with z_valid after 2 cycles; a=0, b=2 gives z=0.
- Busy ignore: a=5, b=1 accepted; next cycle drive a=31, b=3, ab_valid=1. Required: result z=5. The 31×3 pair is accepted only at the next edge where ab_ready=1, yielding 93 three cycles after the first result.
- Reset mid-op: accept a=12, b=3, then assert rst=0 one cycle later. Required: z=0, z_valid never pulses for 36, ab_ready=1 after reset.
- Random soak: 50 cycles of random ab_valid/a/b. Required: every z_valid pulse carries a*b of the pair accepted M cycles earlier.
